// File: rtl/mdu_pkg.sv
// Shared MADOP encodings, default latencies and FSM state type for the MDU.
package mdu_pkg;

   localparam logic [3:0] MADOP_NONE  = 4'd0;
   localparam logic [3:0] MADOP_MULT  = 4'd1;
   localparam logic [3:0] MADOP_MULTU = 4'd2;
   localparam logic [3:0] MADOP_MTHI  = 4'd3;
   localparam logic [3:0] MADOP_MTLO  = 4'd4;
   localparam logic [3:0] MADOP_DIV   = 4'd5;
   localparam logic [3:0] MADOP_DIVU  = 4'd6;
   localparam logic [3:0] MADOP_MADD  = 4'd7;

   localparam int DEF_MULT_CYCLES = 5;
   localparam int DEF_DIV_CYCLES  = 10;

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} mdu_state_t;

endpackage

// File: rtl/mdu_divider.sv
// Combinational 32-bit divide; signed mode truncates toward zero, remainder takes dividend sign.
module mdu_divider (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        sgn,
   output logic [31:0] quo,
   output logic [31:0] rem,
   output logic        div_by_zero
);

   logic        neg_a, neg_b;
   logic [31:0] ua, ub, ub_safe, uq, ur;

   always_comb begin
      neg_a       = sgn & a[31];
      neg_b       = sgn & b[31];
      ua          = neg_a ? -a : a;
      ub          = neg_b ? -b : b;
      div_by_zero = (b == 32'd0);
      // A zero divisor is swapped for 1 so the divider never sees X; the result is discarded anyway.
      ub_safe     = div_by_zero ? 32'd1 : ub;
      uq          = ua / ub_safe;
      ur          = ua % ub_safe;
      quo         = (neg_a ^ neg_b) ? -uq : uq;
      rem         = neg_a ? -ur : ur;
   end

endmodule

// File: rtl/mdu_hilo_unit.sv
// E-stage multiply/divide unit with HI/LO and fixed multi-cycle latency.
// Define MDU_MADD_EN to enable madop 7 (MADD: {hi,lo} += signed rs*rt).
module mdu_hilo_unit
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [3:0]  madop_e,
   input  logic        valid_e,
   input  logic [31:0] rs_e,
   input  logic [31:0] rt_e,
   output logic        start,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = ($clog2(MAXC + 1) < 4) ? 4 : $clog2(MAXC + 1);

   mdu_state_t    state;
   logic [CW-1:0] cnt;
   logic [31:0]   p_hi, p_lo;
   logic          p_wr;

   logic          is_op;
   logic [63:0]   smul, umul;
   logic [31:0]   res_hi, res_lo;
   logic          res_wr;
   logic [CW-1:0] res_lat;
   logic [31:0]   d_quo, d_rem;
   logic          d_dbz;

   mdu_divider u_div (
      .a           (rs_e),
      .b           (rt_e),
      .sgn         (madop_e == MADOP_DIV),
      .quo         (d_quo),
      .rem         (d_rem),
      .div_by_zero (d_dbz)
   );

   always_comb begin
      is_op = 1'b0;
      case (madop_e)
         MADOP_MULT, MADOP_MULTU, MADOP_DIV, MADOP_DIVU: is_op = 1'b1;
`ifdef MDU_MADD_EN
         MADOP_MADD: is_op = 1'b1;
`endif
         default: is_op = 1'b0;
      endcase
   end

   assign start = valid_e & ~busy & is_op;

   assign smul = 64'($signed(rs_e)) * 64'($signed(rt_e));
   assign umul = {32'd0, rs_e} * {32'd0, rt_e};

   always_comb begin
      {res_hi, res_lo} = smul;
      res_wr           = 1'b1;
      res_lat          = CW'(MULT_CYCLES);
      case (madop_e)
         MADOP_MULTU: {res_hi, res_lo} = umul;
         MADOP_DIV, MADOP_DIVU: begin
            res_hi  = d_rem;
            res_lo  = d_quo;
            res_wr  = ~d_dbz;
            res_lat = CW'(DIV_CYCLES);
         end
`ifdef MDU_MADD_EN
         // Accumulates against hi/lo as they stand at the start edge.
         MADOP_MADD: {res_hi, res_lo} = {hi, lo} + smul;
`endif
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= '0;
         busy  <= 1'b0;
         hi    <= '0;
         lo    <= '0;
         p_hi  <= '0;
         p_lo  <= '0;
         p_wr  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  p_hi  <= res_hi;
                  p_lo  <= res_lo;
                  p_wr  <= res_wr;
                  cnt   <= res_lat;
                  busy  <= 1'b1;
                  state <= RUN;
               end else if (valid_e && madop_e == MADOP_MTHI) begin
                  hi <= rs_e;
               end else if (valid_e && madop_e == MADOP_MTLO) begin
                  lo <= rs_e;
               end
            end
            RUN: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  if (p_wr) begin
                     hi <= p_hi;
                     lo <= p_lo;
                  end
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_hilo_unit.sv
// Scoreboard bench for mdu_hilo_unit: expected {hi,lo,latency} queued at start, checked at completion.
module tb_mdu_hilo_unit;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [3:0]  madop_e = 4'd0;
   logic        valid_e = 1'b0;
   logic [31:0] rs_e = '0, rt_e = '0;
   logic        start, busy;
   logic [31:0] hi, lo;

   int   errs = 0;
   int   checks = 0;
   exp_t sb[$];
   exp_t e;

   mdu_hilo_unit dut (
      .clk     (clk),
      .reset_n (reset_n),
      .madop_e (madop_e),
      .valid_e (valid_e),
      .rs_e    (rs_e),
      .rt_e    (rt_e),
      .start   (start),
      .busy    (busy),
      .hi      (hi),
      .lo      (lo)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      valid_e = 1'b1;
      madop_e = op;
      rs_e    = a;
      rt_e    = b;
      #1;
   endtask

   task automatic idle_in();
      valid_e = 1'b0;
      madop_e = 4'd0;
      rs_e    = '0;
      rt_e    = '0;
   endtask

   // Counts busy cycles until the first busy=0 cycle; bounded so a stuck busy shows as a wrong count.
   task automatic wait_done(output int n);
      n = 0;
      while (busy === 1'b1 && n < 40) begin
         n++;
         tick();
      end
   endtask

   task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string name);
      int n;
      drive(op, a, b);
      checks++;
      if (start !== 1'b1) begin errs++; $display("FAIL %s start: got %b want 1", name, start); end
      tick();
      idle_in();
      wait_done(n);
      e = sb.pop_front();
      checks++;
      if (n !== e.lat) begin errs++; $display("FAIL %s latency: got %0d want %0d", name, n, e.lat); end
      checks++;
      if (hi !== e.hi || lo !== e.lo)
         begin errs++; $display("FAIL %s result: got hi=%h lo=%h want hi=%h lo=%h", name, hi, lo, e.hi, e.lo); end
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      idle_in();
      #12;
      checks++;
      if (hi !== 32'd0 || lo !== 32'd0 || busy !== 1'b0)
         begin errs++; $display("FAIL reset: got hi=%h lo=%h busy=%b want 0/0/0", hi, lo, busy); end
      @(negedge clk);
      reset_n = 1'b1;
      tick();
   endtask

   task automatic test_mult();
      sb.push_back('{32'hFFFFFFFF, 32'hFFFFFFFA, 5});
      run_op(4'd1, 32'hFFFFFFFE, 32'd3, "mult_neg2x3");
      sb.push_back('{32'h00000001, 32'hFFFFFFFE, 5});
      run_op(4'd2, 32'hFFFFFFFF, 32'd2, "multu_max_x2");
      sb.push_back('{32'h40000000, 32'h00000000, 5});
      run_op(4'd1, 32'h80000000, 32'h80000000, "mult_minxmin");
   endtask

   task automatic test_div();
      sb.push_back('{32'd2, 32'd14, 10});
      run_op(4'd6, 32'd100, 32'd7, "divu_100_7");
      sb.push_back('{32'hFFFFFFFF, 32'hFFFFFFFD, 10});
      run_op(4'd5, 32'hFFFFFFF9, 32'd2, "div_m7_2");
      sb.push_back('{32'h00000000, 32'h80000000, 10});
      run_op(4'd5, 32'h80000000, 32'hFFFFFFFF, "div_overflow");
   endtask

   task automatic test_divzero();
      drive(4'd3, 32'h1234, 32'd0);
      tick();
      drive(4'd4, 32'h5678, 32'd0);
      checks++;
      if (hi !== 32'h1234 || busy !== 1'b0)
         begin errs++; $display("FAIL mthi: got hi=%h busy=%b want 1234/0", hi, busy); end
      tick();
      idle_in();
      checks++;
      if (lo !== 32'h5678) begin errs++; $display("FAIL mtlo: got lo=%h want 5678", lo); end
      sb.push_back('{32'h1234, 32'h5678, 10});
      run_op(4'd5, 32'd5, 32'd0, "div_by_zero");
   endtask

   task automatic test_reset_mid();
      int n;
      drive(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
      tick();
      idle_in();
      tick();
      tick();
      reset_n = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
         begin errs++; $display("FAIL reset_mid: got busy=%b hi=%h lo=%h want 0/0/0", busy, hi, lo); end
      @(negedge clk);
      reset_n = 1'b1;
      n = 0;
      repeat (15) begin
         tick();
         if (busy !== 1'b0) n++;
      end
      checks++;
      if (n != 0 || hi !== 32'd0 || lo !== 32'd0)
         begin errs++; $display("FAIL reset_mid_nocommit: got busycyc=%0d hi=%h lo=%h want 0/0/0", n, hi, lo); end
   endtask

   task automatic test_back_to_back();
      int n;
      drive(4'd1, 32'd3, 32'd4);
      tick();
      idle_in();
      wait_done(n);
      checks++;
      if (n !== 5 || lo !== 32'd12 || hi !== 32'd0)
         begin errs++; $display("FAIL b2b_mult: got n=%0d hi=%h lo=%h want 5/0/c", n, hi, lo); end
      sb.push_back('{32'd2, 32'd2, 10});
      drive(4'd5, 32'd12, 32'd5);
      checks++;
      if (start !== 1'b1) begin errs++; $display("FAIL b2b_start: got %b want 1", start); end
      tick();
      drive(4'd4, 32'hDEAD, 32'd0);
      checks++;
      if (start !== 1'b0 || busy !== 1'b1)
         begin errs++; $display("FAIL busy_cmd: got start=%b busy=%b want 0/1", start, busy); end
      tick();
      idle_in();
      wait_done(n);
      e = sb.pop_front();
      checks++;
      if (n + 1 !== e.lat || hi !== e.hi || lo !== e.lo)
         begin errs++; $display("FAIL b2b_div: got n=%0d hi=%h lo=%h want %0d/%h/%h", n + 1, hi, lo, e.lat, e.hi, e.lo); end
   endtask

   task automatic test_noop();
      drive(4'd1, 32'd3, 32'd4);
      valid_e = 1'b0;
      #1;
      checks++;
      if (start !== 1'b0) begin errs++; $display("FAIL bubble_start: got %b want 0", start); end
      tick();
      drive(4'd9, 32'd3, 32'd4);
      checks++;
      if (start !== 1'b0) begin errs++; $display("FAIL op9_start: got %b want 0", start); end
      tick();
      idle_in();
      checks++;
      if (busy !== 1'b0 || hi !== 32'd2 || lo !== 32'd2)
         begin errs++; $display("FAIL noop_state: got busy=%b hi=%h lo=%h want 0/2/2", busy, hi, lo); end
   endtask

   task automatic test_madd();
      drive(4'd3, 32'd0, 32'd0);
      tick();
      drive(4'd4, 32'hFFFFFFFF, 32'd0);
      tick();
      idle_in();
`ifdef MDU_MADD_EN
      sb.push_back('{32'd1, 32'd0, 5});
      run_op(4'd7, 32'd1, 32'd1, "madd_carry");
`else
      drive(4'd7, 32'd1, 32'd1);
      checks++;
      if (start !== 1'b0) begin errs++; $display("FAIL madd_off_start: got %b want 0", start); end
      tick();
      idle_in();
      tick();
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'hFFFFFFFF)
         begin errs++; $display("FAIL madd_off_state: got busy=%b hi=%h lo=%h want 0/0/ffffffff", busy, hi, lo); end
`endif
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_divzero();
      test_reset_mid();
      test_back_to_back();
      test_noop();
      test_madd();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
